// File: rtl/alu_nibble_sequencer.sv
// rtl/alu_nibble_sequencer.sv - drives a shared 4-bit ALU slice over a multi-nibble word
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic                 com,
  input  logic                 cin,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
  output logic                 zero,
  output logic                 neg_zero,
  output logic                 equ,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [2:0]           alu_f,
  output logic                 alu_com,
  output logic                 alu_ci_right,
  output logic                 alu_ci_left,
  input  logic [3:0]           alu_d,
  input  logic                 alu_co_left,
  input  logic                 alu_co_right,
  input  logic                 alu_equ
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [W-1:0]  a_q, b_q;
  logic [2:0]    op_q;
  logic          com_q;
  logic          chain_q;   // carry/shift bit handed from one pass to the next
  logic          equ_acc;
  logic [IW-1:0] idx;
  logic [W-1:0]  result_q;
  logic [W-1:0]  result_next;
  logic          carry_q, zero_q, neg_zero_q, equ_q;

  logic          is_shr, uses_right, last_pass, chain_next;
  logic [IW-1:0] pos;

  assign is_shr     = (op_q == OP_SHR);
  assign uses_right = (op_q == OP_ADD) || (op_q == OP_SHL);
  assign last_pass  = (idx == LAST_IDX);
  // Right shifts ripple from the top nibble down, everything else from the bottom up.
  assign pos        = is_shr ? (LAST_IDX - idx) : idx;
  assign chain_next = is_shr ? alu_co_right : alu_co_left;

  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign result    = result_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;
  assign neg_zero  = neg_zero_q;
  assign equ       = equ_q;

  // Slice drive: the current nibble while running, all zeros otherwise.
  always_comb begin
    alu_a        = 4'd0;
    alu_b        = 4'd0;
    alu_f        = 3'd0;
    alu_com      = 1'b0;
    alu_ci_right = 1'b0;
    alu_ci_left  = 1'b0;
    if (state == S_RUN) begin
      alu_a        = a_q[pos*4 +: 4];
      alu_b        = b_q[pos*4 +: 4];
      alu_f        = op_q;
      alu_com      = com_q;
      alu_ci_right = uses_right ? chain_q : 1'b0;
      alu_ci_left  = is_shr ? chain_q : 1'b0;
    end
  end

  // Result word with the nibble from the slice merged in at its position.
  always_comb begin
    result_next = result_q;
    result_next[pos*4 +: 4] = alu_d;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last_pass) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Operand latch, per-nibble capture, chain update and final flag capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 3'd0;
      com_q      <= 1'b0;
      chain_q    <= 1'b0;
      equ_acc    <= 1'b0;
      idx        <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      neg_zero_q <= 1'b0;
      equ_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            com_q   <= com;
            chain_q <= cin;   // first pass uses cin as its carry/shift input
            equ_acc <= 1'b1;
            idx     <= '0;
          end
        end
        S_RUN: begin
          result_q <= result_next;
          chain_q  <= chain_next;
          equ_acc  <= equ_acc & alu_equ;
          idx      <= idx + 1'b1;
          if (last_pass) begin
            carry_q    <= (uses_right || is_shr) ? chain_next : 1'b0;
            zero_q     <= (result_next == '0);
            neg_zero_q <= &result_next;
            equ_q      <= equ_acc & alu_equ;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb/tb_alu_nibble_sequencer.sv - randomized self-checking bench with behavioural 4-bit slice
module tb_alu_nibble_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic        com;
  logic        cin;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] result;
  logic        carry_out, zero, neg_zero, equ;
  logic [3:0]  alu_a, alu_b;
  logic [2:0]  alu_f;
  logic        alu_com, alu_ci_right, alu_ci_left;
  logic [3:0]  alu_d;
  logic        alu_co_left, alu_co_right, alu_equ;

  int checks   = 0;
  int failures = 0;

  alu_nibble_sequencer #(.NIBBLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .com          (com),
    .cin          (cin),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .carry_out    (carry_out),
    .zero         (zero),
    .neg_zero     (neg_zero),
    .equ          (equ),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_f        (alu_f),
    .alu_com      (alu_com),
    .alu_ci_right (alu_ci_right),
    .alu_ci_left  (alu_ci_left),
    .alu_d        (alu_d),
    .alu_co_left  (alu_co_left),
    .alu_co_right (alu_co_right),
    .alu_equ      (alu_equ)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit ALU slice.
  always_comb begin
    logic [4:0] sum;
    logic [3:0] raw;
    sum          = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_ci_right};
    raw          = 4'd0;
    alu_co_left  = 1'b0;
    alu_co_right = 1'b0;
    case (alu_f)
      3'd0: begin raw = sum[3:0]; alu_co_left = sum[4]; end
      3'd1: raw = alu_a & alu_b;
      3'd2: raw = alu_a | alu_b;
      3'd3: raw = alu_a ^ alu_b;
      3'd4: raw = alu_a;
      3'd5: raw = alu_b;
      3'd6: begin raw = {alu_ci_left, alu_a[3:1]}; alu_co_right = alu_a[0]; end
      default: begin raw = {alu_a[2:0], alu_ci_right}; alu_co_left = alu_a[3]; end
    endcase
    alu_d   = alu_com ? ~raw : raw;
    alu_equ = (alu_a == alu_b);
  end

  // Word-level reference model.
  function automatic void ref_model(input logic [2:0] f, input logic c_m, input logic ci,
                                    input logic [15:0] x, input logic [15:0] y,
                                    output logic [15:0] r, output logic co);
    logic [16:0] s;
    co = 1'b0;
    case (f)
      3'd0: begin s = {1'b0, x} + {1'b0, y} + {16'd0, ci}; r = s[15:0]; co = s[16]; end
      3'd1: r = x & y;
      3'd2: r = x | y;
      3'd3: r = x ^ y;
      3'd4: r = x;
      3'd5: r = y;
      3'd6: begin r = {ci, x[15:1]}; co = x[0]; end
      default: begin r = {x[14:0], ci}; co = x[15]; end
    endcase
    if (c_m) r = ~r;
  endfunction

  task automatic run_op(input logic [2:0] f, input logic c_m, input logic ci,
                        input logic [15:0] x, input logic [15:0] y, input string name);
    logic [15:0] er;
    logic        eco;
    int          cycles, busy_cnt;
    ref_model(f, c_m, ci, x, y, er, eco);
    @(negedge clk);
    op = f; com = c_m; cin = ci; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cnt++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s done_timeout got %b exp 1", name, done);
    end
    checks++;
    if (cycles !== 5) begin failures++; $display("FAIL %s latency got %0d exp 5", name, cycles); end
    checks++;
    if (busy_cnt !== 4) begin failures++; $display("FAIL %s busy_cycles got %0d exp 4", name, busy_cnt); end
    checks++;
    if (result !== er) begin failures++; $display("FAIL %s result got %h exp %h", name, result, er); end
    checks++;
    if (carry_out !== eco) begin failures++; $display("FAIL %s carry_out got %b exp %b", name, carry_out, eco); end
    checks++;
    if (zero !== (er == 16'h0)) begin failures++; $display("FAIL %s zero got %b exp %b", name, zero, er == 16'h0); end
    checks++;
    if (neg_zero !== (er == 16'hFFFF)) begin
      failures++; $display("FAIL %s neg_zero got %b exp %b", name, neg_zero, er == 16'hFFFF);
    end
    checks++;
    if (equ !== (x == y)) begin failures++; $display("FAIL %s equ got %b exp %b", name, equ, x == y); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s done_pulse got done=%b busy=%b exp 0 0", name, done, busy);
    end
    checks++;
    if (result !== er) begin failures++; $display("FAIL %s result_held got %h exp %h", name, result, er); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 3'd0; com = 1'b0; cin = 1'b0; a = 16'h0; b = 16'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset busy_done got %b %b exp 0 0", busy, done);
    end
    checks++;
    if (result !== 16'h0) begin failures++; $display("FAIL reset result got %h exp 0000", result); end
    checks++;
    if ({carry_out, zero, neg_zero, equ} !== 4'b0) begin
      failures++; $display("FAIL reset flags got %b exp 0000", {carry_out, zero, neg_zero, equ});
    end
    checks++;
    if ({alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left} !== 14'd0) begin
      failures++; $display("FAIL reset alu_drive got %h exp 0", {alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left});
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, "add_wrap");
    run_op(3'd7, 1'b0, 1'b0, 16'h8001, 16'h0000, "shl");
    run_op(3'd6, 1'b0, 1'b1, 16'h8001, 16'h0000, "shr");
    run_op(3'd3, 1'b1, 1'b0, 16'h1234, 16'h1234, "xor_com");
    checks++;
    if ({alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left} !== 14'd0) begin
      failures++; $display("FAIL idle alu_drive got %h exp 0", {alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left});
    end
  endtask

  task automatic test_and_passb();
    run_op(3'd1, 1'b0, 1'b0, 16'hF0F0, 16'hFF00, "and");
    run_op(3'd5, 1'b0, 1'b0, 16'h1357, 16'h0000, "passb_zero");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
             16'($urandom), (i % 5 == 0) ? 16'h0 : 16'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] first_a, er;
    logic        eco;
    int          cycles, busy_cnt;
    first_a = 16'h4321;
    ref_model(3'd0, 1'b0, 1'b0, first_a, 16'h1111, er, eco);
    @(negedge clk);
    op = 3'd0; com = 1'b0; cin = 1'b0; a = first_a; b = 16'h1111; start = 1'b1;
    cycles = 0; busy_cnt = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cnt++;
      a = 16'($urandom);
    end while (!done && cycles < 20);
    start = 1'b0;
    checks++;
    if (cycles !== 5) begin failures++; $display("FAIL b2b latency got %0d exp 5", cycles); end
    checks++;
    if (busy_cnt !== 4) begin failures++; $display("FAIL b2b busy_cycles got %0d exp 4", busy_cnt); end
    checks++;
    if (result !== er) begin failures++; $display("FAIL b2b result got %h exp %h", result, er); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL b2b after got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    op = 3'd0; com = 1'b0; cin = 1'b0; a = 16'h1234; b = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL midrst busy_done got %b %b exp 0 0", busy, done);
    end
    checks++;
    if (result !== 16'h0) begin failures++; $display("FAIL midrst result got %h exp 0000", result); end
    checks++;
    if (alu_a !== 4'h0 || alu_f !== 3'd0) begin
      failures++; $display("FAIL midrst alu_drive got %h %h exp 0 0", alu_a, alu_f);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL midrst spurious_done got %b exp 0", done); end
    end
    run_op(3'd0, 1'b0, 1'b1, 16'h0FFF, 16'h0000, "after_rst");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_run();
    test_and_passb();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
